// File: rtl/regfile_wb.sv
// Register file with write-back port, same-cycle read bypass and a per-register
// pending scoreboard (issue marks a destination pending, write-back clears it).
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              err_wb
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             pend, pend_nxt;
  logic [ADDR_W:0]             cnt_nxt;
  logic                        wb_on, wb_act, iss_act;

  // Inputs are masked during reset so outputs read all-zero immediately.
  assign wb_on   = wb_en && !reset;
  assign wb_act  = wb_on && (wb_addr != '0);
  assign iss_act = iss_en && !reset && (iss_dst != '0);

  // Issue is applied after write-back so a colliding new producer keeps the bit.
  always_comb begin
    pend_nxt = pend;
    if (wb_act)  pend_nxt[wb_addr] = 1'b0;
    if (iss_act) pend_nxt[iss_dst] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < NREG; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs     <= '0;
      pend     <= '0;
      pend_cnt <= '0;
      err_wb   <= 1'b0;
    end else begin
      if (wb_act) begin
        regs[wb_addr] <= wb_data;
        if (!pend[wb_addr]) err_wb <= 1'b1;
      end
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (wb_on && wb_addr == ra1) ? wb_data : regs[ra1];
    if (ra2 != '0) rd2 = (wb_on && wb_addr == ra2) ? wb_data : regs[ra2];
  end

  // A write-back landing this cycle already satisfies the reader.
  assign busy1 = (ra1 != '0) && pend[ra1] && !(wb_on && wb_addr == ra1);
  assign busy2 = (ra2 != '0) && pend[ra2] && !(wb_on && wb_addr == ra2);
endmodule
